// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory read at a time, with the
// fetched words and their PCs buffered in a DEPTH-entry FIFO; redirect flushes.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inicioPC,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, IDLE, WAIT, DROP} state_t;

  state_t                 r_state;
  logic [31:0]            r_fetch_pc;
  logic [31:0]            r_req_addr;
  logic [AW:0]            r_count;
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [DEPTH-1:0][31:0] r_fifo_instr;
  logic [DEPTH-1:0][31:0] r_fifo_pc;

  logic        w_flush;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_busy;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_busy        = (r_state == WAIT) || (r_state == DROP);
  assign w_flush       = redirect && (r_state != BOOT);
  // Issue only with a free slot: nothing else can push while the read is out.
  assign w_issue       = (r_state == IDLE) && !redirect && (r_count < CNT_FULL);
  assign w_push        = (r_state == WAIT) && im_ack && !redirect;
  assign w_pop         = instr_valid && instr_ready && !w_flush;

  assign im_req      = w_issue || w_busy;
  assign im_addr     = (r_state == IDLE) ? r_fetch_pc : (w_busy ? r_req_addr : 32'h0);
  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_instr[r_rptr];
  assign instr_pc    = r_fifo_pc[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BOOT;
      r_fetch_pc   <= '0;
      r_req_addr   <= '0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_fifo_instr <= '0;
      r_fifo_pc    <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_fetch_pc <= {inicioPC[31:2], 2'b00};
          r_state    <= IDLE;
        end
        IDLE: if (w_issue) begin
          r_req_addr <= r_fetch_pc;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (redirect)
            r_state <= im_ack ? IDLE : DROP;
          else if (im_ack) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= IDLE;
          end
        end
        DROP: if (im_ack) r_state <= IDLE;
        default: r_state <= BOOT;
      endcase

      // Flush overrides the fetch_pc update above and any same-cycle pop.
      if (w_flush) begin
        r_fetch_pc <= w_redirect_pc;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_push) begin
          r_fifo_instr[r_wptr] <= im_data;
          r_fifo_pc[r_wptr]    <= r_req_addr;
          r_wptr               <= r_wptr + 1'b1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)
          r_count <= r_count + 1'b1;
        else if (!w_push && w_pop)
          r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural memory responder plus request/output scoreboards.
`timescale 1ns/1ps
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inicioPC;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .inicioPC(inicioPC),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_data(im_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_req_q[$];
  logic [31:0] exp_out_q[$];
  logic        req_strict;
  int          base_lat, slow_lat, ack_cnt;
  logic [31:0] slow_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    while (exp_out_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("out_drain", exp_out_q.size(), 0);
  endtask

  task automatic wait_req(input logic [31:0] a, input int budget);
    int n = 0;
    logic found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk);
      found = im_req && (im_addr == a);
      n++;
    end
    chk("wait_req", {found, im_addr}, {1'b1, a});
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b0; instr_ready = 1'b0; inicioPC = pc;
    slow_addr = 32'h1; req_strict = 1'b0;
    exp_req_q.delete(); exp_out_q.delete();
    tick(2);
    rst = 1'b0;
  endtask

  // Memory: latches a new request at the falling edge, acks after the chosen latency.
  logic        busy = 1'b0;
  logic [31:0] req_addr;
  int          wcnt;
  initial begin
    im_ack = 1'b0; im_data = '0; ack_cnt = 0; wcnt = 0; req_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy)
          chk("im_hold", {im_req, im_addr}, {1'b1, req_addr});
        else if (im_req && !im_ack) begin
          busy = 1'b1;
          req_addr = im_addr;
          wcnt = (im_addr == slow_addr) ? slow_lat : base_lat;
          if (exp_req_q.size() > 0) chk("req_addr", im_addr, exp_req_q.pop_front());
          else if (req_strict) chk("req_extra", im_req, 0);
        end
      end
      @(posedge clk); #1;
      im_ack = 1'b0;
      if (rst) busy = 1'b0;
      else if (busy) begin
        if (wcnt == 0) begin
          im_ack = 1'b1; im_data = mem_word(req_addr); busy = 1'b0; ack_cnt++;
        end else wcnt--;
      end
    end
  end

  // Consumer side: every accepted pop is checked against the expected PC stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready && !redirect && exp_out_q.size() > 0) begin
        e = exp_out_q.pop_front();
        chk("out_pc", instr_pc, e);
        chk("out_instr", instr, mem_word(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; inicioPC = 32'h40; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    base_lat = 0; slow_lat = 0; slow_addr = 32'h1; req_strict = 1'b0;
    @(negedge clk);
    chk("rst_req", im_req, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);

    // Boot sequence from 0x40
    exp_req_q = '{32'h40, 32'h44, 32'h48};
    exp_out_q = '{32'h40, 32'h44, 32'h48};
    tick(1);
    rst = 1'b0;
    @(negedge clk); chk("boot_noreq", im_req, 0);
    @(negedge clk); chk("first_req", {im_req, im_addr}, {1'b1, 32'h40});
    wait_out(40);
    chk("boot_reqs_left", exp_req_q.size(), 0);

    // Fill with consumer stalled, then resume
    do_reset(32'h0);
    req_strict = 1'b1;
    exp_req_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    tick(20);
    @(negedge clk);
    chk("fill_reqs_left", exp_req_q.size(), 0);
    chk("fill_noreq", im_req, 0);
    chk("fill_head", {instr_valid, instr_pc}, {1'b1, 32'h0});
    tick(1);
    req_strict = 1'b0;
    exp_req_q = '{32'h10};
    exp_out_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    instr_ready = 1'b1;
    wait_out(40);
    chk("resume_reqs_left", exp_req_q.size(), 0);

    // Redirect while the 0x8 read is outstanding
    do_reset(32'h0);
    instr_ready = 1'b1; slow_addr = 32'h8; slow_lat = 6;
    exp_req_q = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_out_q = '{32'h0, 32'h4, 32'h100, 32'h104};
    wait_req(32'h8, 30);
    tick(2);
    redirect_pc = 32'h100; redirect = 1'b1;
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("drop_hold", {im_req, im_addr}, {1'b1, 32'h8});
    chk("drop_valid", instr_valid, 0);
    wait_out(40);
    chk("drop_reqs_left", exp_req_q.size(), 0);

    // Redirect coinciding with the ack for 0x4, FIFO holding 0x0
    do_reset(32'h0);
    slow_addr = 32'h4; slow_lat = 2;
    exp_req_q = '{32'h0, 32'h4, 32'h200};
    exp_out_q = '{32'h200, 32'h204};
    wait_req(32'h4, 30);
    tick(3);
    redirect_pc = 32'h203; redirect = 1'b1;
    tick(1);
    redirect = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("ackrd_flush", instr_valid, 0);
    chk("ackrd_next", {im_req, im_addr}, {1'b1, 32'h200});
    wait_out(40);

    // Redirect in IDLE suppresses issue; fetch wraps past the top of memory
    do_reset(32'h0);
    instr_ready = 1'b1;
    exp_req_q = '{32'hFFFF_FFFC, 32'h0};
    exp_out_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    tick(1);
    redirect_pc = 32'hFFFF_FFFF; redirect = 1'b1;
    @(negedge clk);
    chk("idle_rd_noreq", im_req, 0);
    tick(1);
    redirect = 1'b0;
    wait_out(40);

    // Asynchronous reset with three entries queued, redirect during BOOT ignored
    do_reset(32'h80);
    base = ack_cnt;
    for (int i = 0; i < 40 && ack_cnt < base + 3; i++) @(negedge clk);
    chk("pre_rst_acks", ack_cnt - base, 3);
    @(posedge clk); #3;
    chk("pre_rst_state", {instr_valid, instr_pc}, {1'b1, 32'h80});
    rst = 1'b1;
    #1;
    chk("async_valid", instr_valid, 0);
    chk("async_req", im_req, 0);
    chk("async_pc", instr_pc, 0);
    exp_req_q = '{32'h80};
    exp_out_q = '{32'h80, 32'h84};
    tick(2);
    rst = 1'b0; redirect_pc = 32'h500; redirect = 1'b1; instr_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    wait_out(40);
    chk("boot_rd_reqs_left", exp_req_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the instruction FIFO entries (power of two, >=2).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port inicioPC  input  32  start PC, sampled in BOOT state.
REQ-005 The block SHALL have port im_req  output  1  instruction-memory read request.
REQ-006 The block SHALL have port im_addr  output  32  word-aligned read address, valid while im_req=1.
REQ-007 The block SHALL have port im_ack  input  1  one-cycle pulse: im_data valid this cycle, request complete.
REQ-008 The block SHALL have port im_data  input  32  fetched instruction word.
REQ-009 The block SHALL have port instr_valid  output  1  FIFO head valid (not empty).
REQ-010 The block SHALL have port instr  output  32  FIFO head instruction.
REQ-011 The block SHALL have port instr_pc  output  32  address of FIFO head instruction.
REQ-012 The block SHALL have port instr_ready  input  1  consumer pops head when instr_valid & instr_ready.
REQ-013 The block SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-014 The block SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).

Function
REQ-015 The block SHALL implement states BOOT, IDLE, WAIT, DROP.
REQ-016 BOOT SHALL last one cycle: fetch_pc <= {inicioPC[31:2],2'b00}; next IDLE.
REQ-017 IDLE SHALL assert im_req with im_addr=fetch_pc when count < DEPTH and redirect=0, then enter WAIT next cycle; else remain IDLE with im_req=0.
REQ-018 In WAIT, im_req and im_addr SHALL be held stable until the cycle im_ack=1.
REQ-019 On im_ack in WAIT (no redirect) {im_data, fetch_pc} SHALL be pushed, fetch_pc <= fetch_pc+4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000), next state IDLE.
REQ-020 A new request SHALL issue no earlier than the cycle after the previous im_ack (max one outstanding; throughput one word per two cycles minimum).
REQ-021 Pop SHALL occur when instr_valid & instr_ready; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-022 The FIFO SHALL never overflow: a request issues only if count < DEPTH at issue, and no other push can occur while it is outstanding.
REQ-023 instr, instr_pc SHALL be driven from the FIFO head registers; instr_valid = (count != 0); outputs change only on clk edges.
REQ-024 redirect=1 in any non-BOOT state SHALL: empty FIFO (count <= 0), fetch_pc <= {redirect_pc[31:2],2'b00}; instr_valid=0 from next cycle.
REQ-025 redirect in IDLE SHALL suppress issuing that cycle; next state IDLE.
REQ-026 redirect in WAIT without im_ack SHALL go to DROP; im_req/im_addr stay held with the old address.
REQ-027 redirect in WAIT coinciding with im_ack SHALL discard im_data (no push), next state IDLE.
REQ-028 DROP SHALL hold im_req until im_ack, discard that data, then go IDLE; a further redirect in DROP SHALL only update fetch_pc.
REQ-029 redirect with a simultaneous pop SHALL give redirect priority: FIFO empty afterwards.
REQ-030 redirect in BOOT SHALL be ignored.

Reset
REQ-031 While rst=1 the block SHALL asynchronously force: state BOOT, count 0, FIFO pointers 0, fetch_pc 0, im_req 0, im_addr 0, instr_valid 0, instr 0, instr_pc 0.
REQ-032 Reset asserted mid-request SHALL abandon it; any im_ack after reset release while not in WAIT/DROP SHALL be ignored.
REQ-033 First im_req SHALL assert in the second cycle after rst deasserts (BOOT then IDLE).

Verification
REQ-034 Boot: inicioPC=0x0000_0040, memory acks one cycle after req, instr_ready=1 -> im_addr sequence 0x40,0x44,0x48; instr_pc matches with instr = memory contents.
REQ-035 Fill: instr_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC), im_req then stays 0; raising instr_ready resumes at 0x10.
REQ-036 Redirect in flight: req at 0x8 pending, redirect_pc=0x100 -> im_addr held 0x8 until ack, data dropped, next request 0x100, first instr_pc=0x100.
REQ-037 Redirect with ack same cycle: ack for 0x4 coincides with redirect_pc=0x203 -> no push of 0x4 word, next im_addr=0x200.
REQ-038 Wrap: redirect_pc=0xFFFF_FFFC -> fetched instr_pc sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-039 Async reset: assert rst between clock edges with 3 entries queued -> instr_valid and im_req drop immediately; refetch from inicioPC after release.
